// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared encodings, FSM state type and alignment helper for the
//            sized data memory controller.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // Access size encodings carried on req_size (2'b11 is reserved)
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // An access is rejected when the lane does not sit on its natural boundary
  // or when the reserved size code is used.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = (addr_lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane_align
// Brief    : Combinational lane steering. Merges store data into the old word
//            and extracts/extends the load lane (little-endian lanes).
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic        unsigned_i,
  output logic [31:0] store_word_o,
  output logic [31:0] load_word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  byte_ofs;
  logic [4:0]  half_ofs;

  // Merge the addressed lane into the old word and extend the loaded lane
  always_comb begin
    byte_ofs     = {addr_lo_i, 3'b000};
    half_ofs     = {addr_lo_i[1], 4'b0000};
    byte_sel     = old_word_i[byte_ofs +: 8];
    half_sel     = old_word_i[half_ofs +: 16];
    store_word_o = old_word_i;
    load_word_o  = 32'h0;
    case (size_i)
      SIZE_BYTE: begin
        store_word_o[byte_ofs +: 8] = wdata_i[7:0];
        load_word_o = unsigned_i ? {24'h0, byte_sel}
                                 : {{24{byte_sel[7]}}, byte_sel};
      end
      SIZE_HALF: begin
        store_word_o[half_ofs +: 16] = wdata_i[15:0];
        load_word_o = unsigned_i ? {16'h0, half_sel}
                                 : {{16{half_sel[15]}}, half_sel};
      end
      SIZE_WORD: begin
        store_word_o = wdata_i;
        load_word_o  = old_word_i;
      end
      default: begin
        store_word_o = old_word_i;
        load_word_o  = 32'h0;
      end
    endcase
  end

endmodule : dmem_lane_align
`default_nettype wire

// File: rtl/dmem_sized_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_sized_ctrl
// Brief    : Byte-addressed 32-bit data memory with byte/half/word accesses,
//            valid/ready request handshake, programmable wait states and
//            misalignment detection.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_sized_ctrl
  import dmem_pkg::*;
#(
  parameter int    ADDR_W      = 18,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              resp_valid,
  output logic [31:0]       rdata,
  output logic              misalign_err
);

  localparam int         DEPTH     = 2 ** (ADDR_W - 2);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  logic [31:0]       mem_q [DEPTH];

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              write_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic              accept;
  logic              access_now;
  logic [ADDR_W-3:0] word_idx;
  logic [31:0]       old_word;
  logic [31:0]       store_word;
  logic [31:0]       load_word;
  logic [31:0]       rdata_d;

  assign accept     = req_valid && (state_q == IDLE);
  assign access_now = (state_q == BUSY) && (cnt_q == 4'd0);
  assign word_idx   = addr_q[ADDR_W-1:2];
  assign old_word   = mem_q[word_idx];
  assign rdata_d    = write_q ? 32'h0 : load_word;

  dmem_lane_align u_align (
    .old_word_i   (old_word),
    .size_i       (size_q),
    .addr_lo_i    (addr_q[1:0]),
    .wdata_i      (wdata_q),
    .unsigned_i   (unsigned_q),
    .store_word_o (store_word),
    .load_word_o  (load_word)
  );

  // Capture the request at accept; later input changes are ignored
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q    <= req_write;
      size_q     <= req_size;
      unsigned_q <= req_unsigned;
      addr_q     <= addr;
      wdata_q    <= wdata;
    end
  end

  // Controller FSM with wait-state counter and registered response outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'h0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            if (is_misaligned(req_size, addr[1:0])) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              err_q        <= 1'b1;
              rdata_q      <= 32'h0;
            end else begin
              state_q <= BUSY;
              cnt_q   <= WAIT_INIT;
            end
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            err_q        <= 1'b0;
            rdata_q      <= rdata_d;
          end
        end
        RESP: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          err_q        <= 1'b0;
          rdata_q      <= 32'h0;
        end
        default: begin
          state_q      <= IDLE;
          cnt_q        <= 4'd0;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          err_q        <= 1'b0;
          rdata_q      <= 32'h0;
        end
      endcase
    end
  end

  // Array write on the access edge; reset on the same edge suppresses it
  always_ff @(posedge clk) begin
    if (rst_n && access_now && write_q) begin
      mem_q[word_idx] <= store_word;
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign rdata        = rdata_q;
  assign misalign_err = err_q;

endmodule : dmem_sized_ctrl
`default_nettype wire

// File: tb/tb_dmem_sized_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_sized_ctrl
// Brief    : Self-checking bench: three controller instances (wait states
//            1, 3 and 0), directed table, random traffic against a reference
//            model, reset corner cases and back-to-back throughput.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_sized_ctrl;

  localparam int AW = 12;

  logic        clk = 1'b0;
  logic        rst_n        [3];
  logic        req_valid    [3];
  logic        req_ready    [3];
  logic        req_write    [3];
  logic [1:0]  req_size     [3];
  logic        req_unsigned [3];
  logic [AW-1:0] addr       [3];
  logic [31:0] wdata        [3];
  logic        resp_valid   [3];
  logic [31:0] rdata        [3];
  logic        misalign_err [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WSV = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
    dmem_sized_ctrl #(
      .ADDR_W      (AW),
      .WAIT_STATES (WSV),
      .INIT_FILE   ("")
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n[g]),
      .req_valid    (req_valid[g]),
      .req_ready    (req_ready[g]),
      .req_write    (req_write[g]),
      .req_size     (req_size[g]),
      .req_unsigned (req_unsigned[g]),
      .addr         (addr[g]),
      .wdata        (wdata[g]),
      .resp_valid   (resp_valid[g]),
      .rdata        (rdata[g]),
      .misalign_err (misalign_err[g])
    );
  end

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  logic [31:0] mdl [64];

  function automatic bit mdl_bad(input int sz, input int a);
    if (sz == 3) return 1'b1;
    if (sz == 1) return (a % 2) != 0;
    if (sz == 2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] w, input int sz, input int a, input bit uns);
    longint unsigned v;
    int sh;
    sh = (a % 4) * 8;
    if (sz == 0) begin
      v = (longint'(w) >> sh) % 256;
      if (!uns && v >= 128) v = v + 64'hFFFF_FF00;
    end else if (sz == 1) begin
      v = (longint'(w) >> sh) % 65536;
      if (!uns && v >= 32768) v = v + 64'hFFFF_0000;
    end else begin
      v = longint'(w);
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] mdl_store(input logic [31:0] w, input int sz, input int a, input logic [31:0] wd);
    longint unsigned mask, ins;
    int sh;
    sh = (a % 4) * 8;
    if (sz == 0) begin
      mask = 64'hFF << sh;
      ins  = (longint'(wd) % 256) << sh;
    end else if (sz == 1) begin
      mask = 64'hFFFF << sh;
      ins  = (longint'(wd) % 65536) << sh;
    end else begin
      mask = 64'hFFFF_FFFF;
      ins  = longint'(wd);
    end
    return ((longint'(w) & ~mask) | ins) & 64'hFFFF_FFFF;
  endfunction

  // ---------------- single transaction driver ----------------
  task automatic access(input int k, input bit wr, input bit [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int lat);
    @(negedge clk);
    chk("ready_idle", {31'h0, req_ready[k]}, 32'd1);
    req_write[k]    = wr;
    req_size[k]     = sz;
    req_unsigned[k] = uns;
    addr[k]         = a[AW-1:0];
    wdata[k]        = wd;
    req_valid[k]    = 1'b1;
    @(posedge clk);
    #1;
    req_valid[k]    = 1'b0;
    addr[k]         = AW'($urandom);
    wdata[k]        = $urandom;
    req_size[k]     = 2'($urandom);
    req_unsigned[k] = 1'($urandom);
    lat = 0;
    while (!resp_valid[k] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= 40) begin
      tests++;
      fails++;
      $display("FAIL resp_timeout: got no resp_valid expected one within 40 cycles");
    end
    rd  = rdata[k];
    err = misalign_err[k];
    @(posedge clk);
    #1;
    chk("pulse_width", {31'h0, resp_valid[k]}, 32'd0);
    chk("rdata_idle", rdata[k], 32'h0);
  endtask

  task automatic run_chk(input string nm, input int k, input bit wr, input bit [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input bit exp_err);
    logic [31:0] rd;
    logic        err;
    int          lat;
    access(k, wr, sz, uns, a, wd, rd, err, lat);
    chk({nm, "_rdata"}, rd, exp_rd);
    chk({nm, "_err"}, {31'h0, err}, {31'h0, exp_err});
    chk({nm, "_lat"}, lat, exp_err ? 32'd0 : 32'(ws_of(k) + 1));
  endtask

  typedef struct {
    string       nm;
    bit          wr;
    bit [1:0]    sz;
    bit          uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl [14];

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;
    bit          seen;

    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_write[k] = 1'b0; req_size[k] = 2'b0;
      req_unsigned[k] = 1'b0; addr[k] = '0; wdata[k] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", {31'h0, req_ready[k]}, 32'd1);
      chk("rst_resp", {31'h0, resp_valid[k]}, 32'd0);
      chk("rst_rdata", rdata[k], 32'h0);
      chk("rst_err", {31'h0, misalign_err[k]}, 32'd0);
      rst_n[k] = 1'b1;
    end

    // Directed table, WAIT_STATES=1 instance
    tbl[0]  = '{"sw8",    1'b1, 2'b10, 1'b0, 32'h008, 32'hFEFDFBF7, 32'h0,        1'b0};
    tbl[1]  = '{"lw8",    1'b0, 2'b10, 1'b0, 32'h008, 32'h0,        32'hFEFDFBF7, 1'b0};
    tbl[2]  = '{"lb8",    1'b0, 2'b00, 1'b0, 32'h008, 32'h0,        32'hFFFFFFF7, 1'b0};
    tbl[3]  = '{"lbuB",   1'b0, 2'b00, 1'b1, 32'h00B, 32'h0,        32'h000000FE, 1'b0};
    tbl[4]  = '{"lhA",    1'b0, 2'b01, 1'b0, 32'h00A, 32'h0,        32'hFFFFFEFD, 1'b0};
    tbl[5]  = '{"lhuA",   1'b0, 2'b01, 1'b1, 32'h00A, 32'h0,        32'h0000FEFD, 1'b0};
    tbl[6]  = '{"sbA",    1'b1, 2'b00, 1'b0, 32'h00A, 32'h0000005A, 32'h0,        1'b0};
    tbl[7]  = '{"lw8b",   1'b0, 2'b10, 1'b1, 32'h008, 32'h0,        32'hFE5AFBF7, 1'b0};
    tbl[8]  = '{"sh8",    1'b1, 2'b01, 1'b0, 32'h008, 32'hABCD1234, 32'h0,        1'b0};
    tbl[9]  = '{"lw8c",   1'b0, 2'b10, 1'b0, 32'h008, 32'h0,        32'hFE5A1234, 1'b0};
    tbl[10] = '{"lw6err", 1'b0, 2'b10, 1'b0, 32'h006, 32'h0,        32'h0,        1'b1};
    tbl[11] = '{"sh9err", 1'b1, 2'b01, 1'b0, 32'h009, 32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[12] = '{"sz3err", 1'b1, 2'b11, 1'b0, 32'h008, 32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[13] = '{"lw8d",   1'b0, 2'b10, 1'b0, 32'h008, 32'h0,        32'hFE5A1234, 1'b0};
    for (int i = 0; i < 14; i++)
      run_chk(tbl[i].nm, 0, tbl[i].wr, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].wd,
              tbl[i].exp_rd, tbl[i].exp_err);

    // Random traffic on words 0..15 of instance 0 against the model
    for (int w = 0; w < 16; w++) begin
      mdl[w] = $urandom;
      run_chk("rinit", 0, 1'b1, 2'b10, 1'b0, 32'(w * 4), mdl[w], 32'h0, 1'b0);
    end
    for (int i = 0; i < 200; i++) begin
      bit          wr, uns, bad;
      int          sz, a;
      logic [31:0] wd, exp_rd;
      wr  = 1'($urandom);
      uns = 1'($urandom);
      sz  = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
      a   = $urandom_range(0, 63);
      wd  = $urandom;
      bad = mdl_bad(sz, a);
      exp_rd = 32'h0;
      if (!bad && wr)  mdl[a / 4] = mdl_store(mdl[a / 4], sz, a, wd);
      if (!bad && !wr) exp_rd = mdl_load(mdl[a / 4], sz, a, uns);
      run_chk("rand", 0, wr, 2'(sz), uns, 32'(a), wd, exp_rd, bad);
    end

    // Reset during the second BUSY cycle, WAIT_STATES=3 instance
    run_chk("ws3_sw", 1, 1'b1, 2'b10, 1'b0, 32'h010, 32'h11112222, 32'h0, 1'b0);
    @(negedge clk);
    req_write[1] = 1'b1; req_size[1] = 2'b10; addr[1] = 'h010; wdata[1] = 32'h00003FFF;
    req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      seen |= resp_valid[1];
    end
    rst_n[1] = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      seen |= resp_valid[1];
    end
    chk("ws3_no_resp", {31'h0, seen}, 32'd0);
    chk("ws3_ready_after_rst", {31'h0, req_ready[1]}, 32'd1);
    run_chk("ws3_lw", 1, 1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 32'h11112222, 1'b0);

    // Reset coinciding with the access edge, WAIT_STATES=0 instance
    run_chk("ws0_sw", 2, 1'b1, 2'b10, 1'b0, 32'h020, 32'hA5A5A5A5, 32'h0, 1'b0);
    @(negedge clk);
    req_write[2] = 1'b1; req_size[2] = 2'b10; addr[2] = 'h020; wdata[2] = 32'h0000DEAD;
    req_valid[2] = 1'b1;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    rst_n[2] = 1'b0;
    @(posedge clk); #1;
    rst_n[2] = 1'b1;
    seen = resp_valid[2];
    repeat (4) begin
      @(posedge clk); #1;
      seen |= resp_valid[2];
    end
    chk("ws0_no_resp", {31'h0, seen}, 32'd0);
    run_chk("ws0_lw", 2, 1'b0, 2'b10, 1'b0, 32'h020, 32'h0, 32'hA5A5A5A5, 1'b0);

    // Back-to-back loads with req_valid held high, WAIT_STATES=0 instance
    begin
      logic [31:0] vals [4];
      int          acc_cyc [4];
      int          nacc, nresp, cyc;
      bit          rdy;
      for (int i = 0; i < 4; i++) begin
        vals[i] = 32'h1000_0000 + 32'(i * 32'h0101_0101);
        run_chk("b2b_init", 2, 1'b1, 2'b10, 1'b0, 32'(i * 4), vals[i], 32'h0, 1'b0);
      end
      nacc = 0; nresp = 0; cyc = 0;
      @(negedge clk);
      req_write[2] = 1'b0; req_size[2] = 2'b10; req_unsigned[2] = 1'b0;
      addr[2] = '0; req_valid[2] = 1'b1;
      while ((nacc < 4 || nresp < 4) && cyc < 60) begin
        rdy = req_ready[2] && req_valid[2];
        @(posedge clk); #1;
        if (rdy) begin
          acc_cyc[nacc] = cyc;
          nacc++;
          if (nacc < 4) addr[2] = AW'(nacc * 4);
          else req_valid[2] = 1'b0;
        end
        if (resp_valid[2]) begin
          if (nresp < 4) chk("b2b_rdata", rdata[2], vals[nresp]);
          nresp++;
        end
        @(negedge clk);
        cyc++;
      end
      req_valid[2] = 1'b0;
      chk("b2b_accepts", nacc, 32'd4);
      chk("b2b_resps", nresp, 32'd4);
      for (int i = 1; i < 4; i++)
        if (i < nacc) chk("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 32'd3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_dmem_sized_ctrl
`default_nettype wire
